// File: rtl/logic_unit_fu.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_fu
// Purpose  : Pipelined bitwise logic functional unit. Accepts an issued op
//            (valid/ready), evaluates one of eight bitwise functions, registers
//            the tagged result in stage S1, then buffers it in a DEPTH-entry
//            circular queue that requests the common data bus (req/grant).
// Ports    : clk, reset (async, active-high), flush (sync squash)
//            issue_valid/issue_ready/issue_op/issue_src1/issue_src2/issue_tag
//            cdb_req/cdb_grant/cdb_tag/cdb_data
//            busy (S1 or queue occupied), q_count (queue occupancy)
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_fu #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [2:0]                 issue_op,
    input  logic [WIDTH-1:0]           issue_src1,
    input  logic [WIDTH-1:0]           issue_src2,
    input  logic [TAG_W-1:0]           issue_tag,
    output logic                       cdb_req,
    input  logic                       cdb_grant,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [WIDTH-1:0]           cdb_data,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] C_OP_AND  = 3'b000;
    localparam logic [2:0] C_OP_OR   = 3'b001;
    localparam logic [2:0] C_OP_XOR  = 3'b010;
    localparam logic [2:0] C_OP_NAND = 3'b011;
    localparam logic [2:0] C_OP_NOR  = 3'b100;
    localparam logic [2:0] C_OP_XNOR = 3'b101;
    localparam logic [2:0] C_OP_NOT  = 3'b110;
    localparam logic [2:0] C_OP_PASS = 3'b111;

    localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                   s1_valid_q, s1_valid_d;
    logic [TAG_W-1:0]       s1_tag_q,   s1_tag_d;
    logic [WIDTH-1:0]       s1_res_q,   s1_res_d;

    logic [PTR_W-1:0]       wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]       count_q,    count_d;

    logic [TAG_W-1:0]       tag_mem_q  [DEPTH];
    logic [TAG_W-1:0]       tag_mem_d  [DEPTH];
    logic [WIDTH-1:0]       data_mem_q [DEPTH];
    logic [WIDTH-1:0]       data_mem_d [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                   w_result_valid_unused;
    logic [WIDTH-1:0]       w_result;
    logic                   w_q_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_s1_advance;
    logic                   w_issue_fire;

    assign w_result_valid_unused = 1'b0;

    always_comb begin
        w_result = issue_src1;
        case (issue_op)
            C_OP_AND:  w_result = issue_src1 & issue_src2;
            C_OP_OR:   w_result = issue_src1 | issue_src2;
            C_OP_XOR:  w_result = issue_src1 ^ issue_src2;
            C_OP_NAND: w_result = ~(issue_src1 & issue_src2);
            C_OP_NOR:  w_result = ~(issue_src1 | issue_src2);
            C_OP_XNOR: w_result = ~(issue_src1 ^ issue_src2);
            C_OP_NOT:  w_result = ~issue_src1;
            C_OP_PASS: w_result = issue_src1;
            default:   w_result = issue_src1;
        endcase
    end

    assign w_q_full     = (count_q == C_FULL_COUNT);
    assign cdb_req      = (count_q != '0);
    // A grant with nothing at the head is simply ignored.
    assign w_pop        = cdb_req && cdb_grant;
    // S1 may move into a full queue only when the head leaves on this edge.
    assign w_s1_advance = s1_valid_q && (!w_q_full || w_pop);
    assign w_push       = w_s1_advance;
    // Ready depends on the grant combinationally so a pop frees S1 and the
    // issue slot within the same cycle.
    assign issue_ready  = !flush && (!s1_valid_q || w_s1_advance);
    assign w_issue_fire = issue_valid && issue_ready;

    assign busy     = s1_valid_q || (count_q != '0);
    assign q_count  = count_q;
    assign cdb_tag  = tag_mem_q[rd_ptr_q];
    assign cdb_data = data_mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Next-state: execute stage S1
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_tag_d   = s1_tag_q;
        s1_res_d   = s1_res_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (w_issue_fire) begin
            s1_valid_d = 1'b1;
            s1_tag_d   = issue_tag;
            s1_res_d   = w_result;
        end else if (w_s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: result queue
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tag_mem_d  = tag_mem_q;
        data_mem_d = data_mem_q;
        if (flush) begin
            // Storage is left as-is; with count 0 it is never presented.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                tag_mem_d[wr_ptr_q]  = s1_tag_q;
                data_mem_d[wr_ptr_q] = s1_res_q;
                // DEPTH is a power of two, so natural overflow wraps the pointer.
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            s1_res_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i]  <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            s1_res_q   <= s1_res_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i]  <= tag_mem_d[i];
                data_mem_q[i] <= data_mem_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_fu.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_fu
// Purpose  : Self-checking bench for logic_unit_fu. A default-parameter
//            instance is driven with directed sequences and random traffic
//            against an in-order scoreboard whose results come from per-bit
//            truth tables; a second narrow instance (8/2/4) gets a short
//            directed check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_fu;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] data;
    } sb_ent_t;

    // ---------------- DUT A (32/4/2) ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic        issue_ready;
    logic [2:0]  issue_op;
    logic [31:0] issue_src1;
    logic [31:0] issue_src2;
    logic [3:0]  issue_tag;
    logic        cdb_req;
    logic        cdb_grant;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        busy;
    logic [1:0]  q_count;

    // ---------------- DUT B (8/2/4) ----------------
    logic        flush_b;
    logic        issue_valid_b;
    logic        issue_ready_b;
    logic [2:0]  issue_op_b;
    logic [7:0]  issue_src1_b;
    logic [7:0]  issue_src2_b;
    logic [1:0]  issue_tag_b;
    logic        cdb_req_b;
    logic        cdb_grant_b;
    logic [1:0]  cdb_tag_b;
    logic [7:0]  cdb_data_b;
    logic        busy_b;
    logic [2:0]  q_count_b;

    logic_unit_fu #(.WIDTH(32), .TAG_W(4), .DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_op   (issue_op),
        .issue_src1 (issue_src1),
        .issue_src2 (issue_src2),
        .issue_tag  (issue_tag),
        .cdb_req    (cdb_req),
        .cdb_grant  (cdb_grant),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .busy       (busy),
        .q_count    (q_count)
    );

    logic_unit_fu #(.WIDTH(8), .TAG_W(2), .DEPTH(4)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush_b),
        .issue_valid(issue_valid_b),
        .issue_ready(issue_ready_b),
        .issue_op   (issue_op_b),
        .issue_src1 (issue_src1_b),
        .issue_src2 (issue_src2_b),
        .issue_tag  (issue_tag_b),
        .cdb_req    (cdb_req_b),
        .cdb_grant  (cdb_grant_b),
        .cdb_tag    (cdb_tag_b),
        .cdb_data   (cdb_data_b),
        .busy       (busy_b),
        .q_count    (q_count_b)
    );

    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_fail   = 0;
    sb_ent_t sb[$];

    logic       s_req;
    logic       s_rdy;
    logic [1:0] s_cnt;

    logic [31:0] sweep_exp [8] = '{
        32'hF000_0000, 32'hFFF0_FFFF, 32'h0FF0_FFFF, 32'h0FFF_FFFF,
        32'h000F_0000, 32'hF00F_0000, 32'h0F0F_5A5A, 32'hF0F0_A5A5
    };

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each op is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [31:0] ref_logic(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [3:0]  tt;
        logic [31:0] r;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0111;
            3'd4:    tt = 4'b0001;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 32; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    // One clock cycle on DUT A: drive at negedge, check just after, update
    // the scoreboard with what the edge accepted and retired.
    task automatic step(input logic v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic [31:0] exp_d,
                        input logic g, input logic f,
                        output logic req_s, output logic rdy_s,
                        output logic [1:0] cnt_s);
        logic fire;
        logic pop;
        @(negedge clk);
        issue_valid = v;
        issue_op    = op;
        issue_src1  = a;
        issue_src2  = b;
        issue_tag   = t;
        cdb_grant   = g;
        flush       = f;
        #1;
        req_s = cdb_req;
        rdy_s = issue_ready;
        cnt_s = q_count;
        fire  = v && issue_ready;
        pop   = cdb_req && g;
        chk_val("busy", busy, (sb.size() != 0));
        chk_val("issue_ready", issue_ready, !f && ((sb.size() < DEPTH + 1) || g));
        if (pop) begin
            if (sb.size() == 0) begin
                chk_val("spurious_req", cdb_req, 1'b0);
            end else begin
                chk_val("cdb_tag", cdb_tag, sb[0].tag);
                chk_val("cdb_data", cdb_data, sb[0].data);
            end
        end
        @(posedge clk);
        if (f) begin
            sb.delete();
        end else begin
            if (pop && sb.size() != 0) void'(sb.pop_front());
            if (fire) sb.push_back('{tag: t, data: exp_d});
        end
    endtask

    task automatic idle(input logic g);
        step(1'b0, 3'd0, 32'h0, 32'h0, 4'h0, 32'h0, g, 1'b0, s_req, s_rdy, s_cnt);
    endtask

    task automatic issue_ref(input logic [2:0] op, input logic [3:0] t, input logic g);
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom;
        step(1'b1, op, a, b, t, ref_logic(op, a, b), g, 1'b0, s_req, s_rdy, s_cnt);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 20) begin
            idle(1'b1);
            k++;
        end
        if (k >= 20) chk_val("drain_timeout", busy, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        issue_valid   = 1'b0;
        issue_op      = 3'd0;
        issue_src1    = '0;
        issue_src2    = '0;
        issue_tag     = '0;
        cdb_grant     = 1'b0;
        flush_b       = 1'b0;
        issue_valid_b = 1'b0;
        issue_op_b    = 3'd0;
        issue_src1_b  = '0;
        issue_src2_b  = '0;
        issue_tag_b   = '0;
        cdb_grant_b   = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        chk_val("rst_q_count", q_count, 2'd0);
        chk_val("rst_cdb_req", cdb_req, 1'b0);
        chk_val("rst_busy", busy, 1'b0);
        chk_val("rst_issue_ready", issue_ready, 1'b1);
        chk_val("rst_cdb_tag", cdb_tag, 4'h0);
        chk_val("rst_cdb_data", cdb_data, 32'h0);
        reset = 1'b0;

        // ---- op sweep, grant held high ----
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 32'hF0F0_A5A5, 32'hFF00_5A5A, 4'(i), sweep_exp[i],
                 1'b1, 1'b0, s_req, s_rdy, s_cnt);
            if (i == 1) chk_val("latency_n1_req", s_req, 1'b0);
            if (i == 2) chk_val("latency_n2_req", s_req, 1'b1);
        end
        drain();

        // ---- backpressure ----
        for (int i = 1; i <= 3; i++) issue_ref(3'(i), 4'(i), 1'b0);
        idle(1'b0);
        chk_val("bp_ready_low", s_rdy, 1'b0);
        chk_val("bp_q_count", s_cnt, 2'd2);
        idle(1'b1);
        chk_val("bp_ready_in_grant", s_rdy, 1'b1);
        idle(1'b0);
        chk_val("bp_q_count_after", s_cnt, 2'd2);
        chk_val("bp_head_tag2", cdb_tag, 4'd2);
        drain();

        // ---- sustained push+pop with full queue ----
        for (int i = 0; i < 3; i++) issue_ref(3'(i), 4'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            issue_ref(3'($urandom_range(0, 7)), 4'(3 + i), 1'b1);
            chk_val("sus_q_count", s_cnt, 2'd2);
            chk_val("sus_ready", s_rdy, 1'b1);
        end
        drain();

        // ---- flush with 3 in flight, issue and grant in flush cycle ----
        for (int i = 0; i < 3; i++) issue_ref(3'(i), 4'(i + 8), 1'b0);
        step(1'b1, 3'd7, 32'hDEAD_BEEF, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b1,
             s_req, s_rdy, s_cnt);
        chk_val("flush_ready_low", s_rdy, 1'b0);
        idle(1'b0);
        chk_val("flush_q_count", s_cnt, 2'd0);
        chk_val("flush_cdb_req", s_req, 1'b0);
        repeat (3) idle(1'b1);

        // ---- async reset mid-stream ----
        issue_ref(3'd1, 4'd5, 1'b0);
        idle(1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_val("arst_cdb_req", cdb_req, 1'b0);
        chk_val("arst_busy", busy, 1'b0);
        chk_val("arst_q_count", q_count, 2'd0);
        sb.delete();
        #1 reset = 1'b0;
        issue_ref(3'd2, 4'd9, 1'b1);
        idle(1'b1);
        chk_val("arst_lat_n1", s_req, 1'b0);
        idle(1'b1);
        chk_val("arst_lat_n2", s_req, 1'b1);
        drain();

        // ---- random traffic ----
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [2:0]  op;
            a  = $urandom;
            b  = $urandom;
            op = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 3) != 0), op, a, b, 4'($urandom), ref_logic(op, a, b),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0),
                 s_req, s_rdy, s_cnt);
        end
        drain();

        // ---- narrow instance: NAND, fill without grant ----
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            issue_valid_b = 1'b1;
            issue_op_b    = 3'b011;
            issue_src1_b  = 8'hC3;
            issue_src2_b  = 8'h0F;
            issue_tag_b   = 2'(i);
            #1 chk_val("b_ready_fill", issue_ready_b, 1'b1);
        end
        @(negedge clk);
        issue_valid_b = 1'b0;
        #1;
        chk_val("b_q_count", q_count_b, 3'd4);
        chk_val("b_ready_full", issue_ready_b, 1'b0);
        chk_val("b_busy", busy_b, 1'b1);
        chk_val("b_cdb_tag", cdb_tag_b, 2'd0);
        chk_val("b_cdb_data", cdb_data_b, 8'hFC);
        cdb_grant_b = 1'b1;
        #1 chk_val("b_ready_grant", issue_ready_b, 1'b1);
        @(negedge clk);
        cdb_grant_b = 1'b0;
        #1;
        chk_val("b_q_count_after", q_count_b, 3'd4);
        chk_val("b_head_tag1", cdb_tag_b, 2'd1);
        cdb_grant_b = 1'b1;
        repeat (8) @(negedge clk);
        #1 chk_val("b_drained", busy_b, 1'b0);
        cdb_grant_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
